ram_lsu: RTL and testbench

//   Load/store initiator that drives the single-clock 256x32 data RAM port (write strobes
//   prt_en_1/we, read strobes prt_en_0/oe, registered read data one cycle after strobe).

---
 rtl/ram_lsu_if.sv | 24 ++
 rtl/ram_lsu.sv | 164 ++++++++++++++++
 tb/tb_ram_lsu.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_lsu_if.sv
// Request/response handshake bundle between a load/store client and ram_lsu.
interface ram_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_lsu.sv
// Load/store initiator for a 32-bit word RAM without byte enables: sub-word stores
// are done as read-modify-write, loads are lane-extracted and sign/zero extended.
module ram_lsu #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  ram_lsu_if.slave    bus,
  output logic        mem_we,
  output logic        mem_prt_en_1,
  output logic        mem_oe,
  output logic        mem_prt_en_0,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              accept_s;
  logic              err_s;
  logic              we_r;
  logic [1:0]        size_r;
  logic              signed_r;
  logic [ADDR_W+1:0] addr_r;
  logic [31:0]       mem_wdata_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_err_r;

  function automatic logic req_is_bad(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad | ((addr >> (ADDR_W + 2)) != 32'd0);
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign accept_s = bus.req_valid & (state_r == IDLE);
  assign err_s    = req_is_bad(bus.req_size, bus.req_addr);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nxt_s = IDLE;
        end else if (err_s) begin
          state_nxt_s = RESP;
        end else if (bus.req_we && (bus.req_size == 2'b10)) begin
          state_nxt_s = WR;
        end else begin
          state_nxt_s = RD;
        end
      end
      RD:  state_nxt_s = CAP;
      CAP: begin
        if (we_r) begin
          state_nxt_s = WR;
        end else begin
          state_nxt_s = RESP;
        end
      end
      WR:  state_nxt_s = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request latch, read-data capture and merge; CAP is the only cycle mem_rdata is sampled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r        <= 1'b0;
      size_r      <= 2'b00;
      signed_r    <= 1'b0;
      addr_r      <= '0;
      mem_wdata_r <= 32'h0000_0000;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      we_r        <= bus.req_we;
      size_r      <= bus.req_size;
      signed_r    <= bus.req_signed;
      addr_r      <= bus.req_addr[ADDR_W+1:0];
      mem_wdata_r <= bus.req_wdata;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= err_s;
    end else if (state_r == CAP) begin
      if (we_r) begin
        mem_wdata_r <= merge_store(mem_rdata, mem_wdata_r, addr_r[1:0], size_r);
      end else begin
        rsp_rdata_r <= extract_load(mem_rdata, addr_r[1:0], size_r, signed_r);
      end
    end
  end

  // Strobes are pure state decodes so an async reset removes them immediately
  assign mem_oe        = (state_r == RD);
  assign mem_prt_en_0  = (state_r == RD);
  assign mem_we        = (state_r == WR);
  assign mem_prt_en_1  = (state_r == WR);
  assign mem_addr      = {{(32 - ADDR_W){1'b0}}, addr_r[ADDR_W+1:2]};
  assign mem_wdata     = mem_wdata_r;

  assign bus.req_ready = (state_r == IDLE);
  assign bus.rsp_valid = (state_r == RESP);
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_ram_lsu.sv
// Scoreboard bench for ram_lsu: directed requests push expected responses, a negedge
// monitor pops and compares; a behavioural 256x32 RAM models the memory port.
module tb_ram_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we, mem_prt_en_1, mem_oe, mem_prt_en_0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] ram [0:255];

  ram_lsu_if bus();

  ram_lsu #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_we(mem_we), .mem_prt_en_1(mem_prt_en_1), .mem_oe(mem_oe), .mem_prt_en_0(mem_prt_en_0),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          overlap = 0;
  int          rsp_cnt = 0;
  int          acc_cyc = 0;
  logic [31:0] last_rd_addr = 32'h0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_rdata = 32'h0;
  logic        prev_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  // Behavioural RAM: preload on first edge, then registered read / write
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[4] <= 32'h0BAD_F00D;
    end else if (mem_we && mem_prt_en_1) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_oe && mem_prt_en_0) mem_rdata <= ram[mem_addr[7:0]];
  end

  // Cycle and strobe accounting
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_oe && mem_prt_en_0) rd_cnt <= rd_cnt + 1;
    if (mem_we && mem_prt_en_1) wr_cnt <= wr_cnt + 1;
    if ((mem_oe || mem_prt_en_0) && (mem_we || mem_prt_en_1)) overlap <= overlap + 1;
    if (mem_oe) last_rd_addr <= mem_addr;
  end

  // Response monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      if (bus.rsp_valid && !prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=valid required=none");
        end else begin
          chk("latency", 32'(cyc - acc_cyc), 32'(q[0].lat));
        end
      end
      if (bus.rsp_valid && prev_valid) begin
        chk("hold_rdata", bus.rsp_rdata, prev_rdata);
        chk("hold_err", {31'd0, bus.rsp_err}, {31'd0, prev_err});
      end
      if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        rsp_cnt++;
      end
      prev_valid = bus.rsp_valid;
      prev_rdata = bus.rsp_rdata;
      prev_err   = bus.rsp_err;
    end
  end

  task automatic do_req(input string nm, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata_x, input logic err_x,
                        input int lat_x, input int rd_x, input int wr_x);
    int rd0, wr0, n0;
    bit got;
    @(posedge clk); #1;
    rd0 = rd_cnt; wr0 = wr_cnt; n0 = rsp_cnt;
    q.push_back('{rdata_x, err_x, lat_x});
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.rsp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (!got) begin
      fail_now({nm, "_accept"});
      q.delete();
      return;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (rsp_cnt != n0) got = 1'b1;
    end
    if (!got) begin
      fail_now({nm, "_rsp"});
      q.delete();
      return;
    end
    chk({nm, "_rd_strobes"}, 32'(rd_cnt - rd0), 32'(rd_x));
    chk({nm, "_wr_strobes"}, 32'(wr_cnt - wr0), 32'(wr_x));
  endtask

  initial begin
    int  rd0, n0;
    bit  got;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_strobes", {28'd0, mem_we, mem_prt_en_1, mem_oe, mem_prt_en_0}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    do_req("st_w", 1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1);
    chk("ram3_word", ram[3], 32'hDEAD_BEEF);
    do_req("ld_w", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1, 0);
    chk("ld_w_mem_addr", last_rd_addr, 32'd3);
    do_req("st_b", 1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_00A5, 32'h0, 1'b0, 4, 1, 1);
    chk("ram3_byte", ram[3], 32'hDEAD_A5EF);
    do_req("ld_bs", 1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 32'hFFFF_FFA5, 1'b0, 3, 1, 0);
    do_req("ld_bu", 1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 32'h0000_00A5, 1'b0, 3, 1, 0);
    do_req("ld_hs", 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 32'hFFFF_DEAD, 1'b0, 3, 1, 0);
    do_req("ld_hu", 1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'h0000_DEAD, 1'b0, 3, 1, 0);
    do_req("ld_h_mis", 1'b0, 2'b01, 1'b1, 32'h0F, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("ld_w_oor", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("st_h", 1'b1, 2'b01, 1'b0, 32'h0E, 32'hFFFF_1234, 32'h0, 1'b0, 4, 1, 1);
    chk("ram3_half", ram[3], 32'h1234_A5EF);
    do_req("ld_hu_lo", 1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, 32'h0000_A5EF, 1'b0, 3, 1, 0);
    do_req("ld_bu_3", 1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 32'h0000_0012, 1'b0, 3, 1, 0);
    do_req("ld_bs_2", 1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 32'h0000_0034, 1'b0, 3, 1, 0);
    do_req("st_w_mis", 1'b1, 2'b10, 1'b0, 32'h0E, 32'hCAFE_F00D, 32'h0, 1'b1, 1, 0, 0);
    do_req("st_sz3", 1'b1, 2'b11, 1'b0, 32'h0C, 32'hCAFE_F00D, 32'h0, 1'b1, 1, 0, 0);
    chk("ram3_after_err", ram[3], 32'h1234_A5EF);

    // Back-pressured load with an extra request presented while busy
    @(posedge clk); #1;
    rd0 = rd_cnt; n0 = rsp_cnt;
    q.push_back('{32'h1234_A5EF, 1'b0, 3});
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0C; bus.rsp_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
    end
    if (!got) fail_now("bp_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_addr = 32'h20;
      @(negedge clk);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'h1234_A5EF);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (rsp_cnt != n0) got = 1'b1;
    end
    if (!got) fail_now("bp_handshake");
    repeat (5) @(negedge clk);
    chk("bp_no_extra_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    chk("bp_rd_strobes", 32'(rd_cnt - rd0), 32'd1);

    // Reset pulsed during the write cycle of a word store
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_wr_state", {31'd0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {28'd0, mem_we, mem_prt_en_1, mem_oe, mem_prt_en_0}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_mid_rsp", {bus.rsp_rdata[30:0], bus.rsp_valid}, 32'd0);
    chk("rst_mid_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'h0);
    chk("rst_mid_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ram4_unchanged", ram[4], 32'h0BAD_F00D);

    do_req("st_w_post", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 2, 0, 1);
    chk("ram4_written", ram[4], 32'h1234_5678);
    do_req("ld_w_post", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 3, 1, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("rd_wr_overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
